// File: rtl/audio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | audio_pkg: shared types and constants for the audio channel envelope logic. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package audio_pkg;

  localparam int ENV_LEVEL_W = 16;
  localparam logic [ENV_LEVEL_W-1:0] ENV_LEVEL_MAX = 16'hFF00;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/audio_tick_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | audio_tick_gen: free-running prescaler, one-cycle tick every DIV cycles.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module audio_tick_gen #(
  parameter int DIV = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic tick_o
);

  localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick_o = (r_count == c_last);

endmodule : audio_tick_gen
`default_nettype wire

// File: rtl/audio_envelope.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | audio_envelope: ADSR envelope generator producing an 8-bit channel volume.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module audio_envelope
  import audio_pkg::*;
#(
  parameter int TICK_DIV = 256
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       gate_i,
  input  logic [7:0] attack_i,
  input  logic [7:0] decay_i,
  input  logic [7:0] sustain_i,
  input  logic [7:0] release_i,
  output logic [7:0] volume_o,
  output logic       active_o,
  output logic [2:0] state_o
);

  env_state_t             r_state;
  env_state_t             w_next_state;
  logic [ENV_LEVEL_W-1:0] r_level;
  logic [ENV_LEVEL_W-1:0] w_next_level;
  logic                   r_gate;
  logic                   r_active;
  logic                   w_tick;
  logic                   w_rise;
  logic                   w_fall;
  logic [ENV_LEVEL_W-1:0] w_sus_t;
  logic [ENV_LEVEL_W:0]   w_att_sum;
  logic [ENV_LEVEL_W:0]   w_dec_diff;
  logic [ENV_LEVEL_W:0]   w_rel_diff;

  audio_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .tick_o (w_tick)
  );

  assign w_rise  = gate_i & ~r_gate;
  assign w_fall  = ~gate_i & r_gate;
  assign w_sus_t = {sustain_i, 8'h00};

  // 17-bit step arithmetic: bit 16 flags overflow (attack) or borrow (decay/release)
  assign w_att_sum  = {1'b0, r_level} + {9'h000, attack_i};
  assign w_dec_diff = {1'b0, r_level} - {9'h000, decay_i};
  assign w_rel_diff = {1'b0, r_level} - {9'h000, release_i};

  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    if (w_rise) begin
      w_next_state = ENV_ATTACK;
    end else if (w_fall && (r_state == ENV_ATTACK || r_state == ENV_DECAY ||
                            r_state == ENV_SUSTAIN)) begin
      w_next_state = ENV_RELEASE;
    end else begin
      case (r_state)
        ENV_ATTACK: begin
          if (attack_i == 8'h00) begin
            w_next_level = ENV_LEVEL_MAX;
            w_next_state = ENV_DECAY;
          end else if (w_tick) begin
            if (w_att_sum >= {1'b0, ENV_LEVEL_MAX}) begin
              w_next_level = ENV_LEVEL_MAX;
              w_next_state = ENV_DECAY;
            end else begin
              w_next_level = w_att_sum[ENV_LEVEL_W-1:0];
            end
          end
        end
        ENV_DECAY: begin
          if (r_level <= w_sus_t || decay_i == 8'h00) begin
            w_next_level = w_sus_t;
            w_next_state = ENV_SUSTAIN;
          end else if (w_tick) begin
            if (w_dec_diff[ENV_LEVEL_W] || w_dec_diff[ENV_LEVEL_W-1:0] < w_sus_t) begin
              w_next_level = w_sus_t;
            end else begin
              w_next_level = w_dec_diff[ENV_LEVEL_W-1:0];
            end
          end
        end
        ENV_SUSTAIN: begin
          w_next_level = w_sus_t;
        end
        ENV_RELEASE: begin
          if (release_i == 8'h00 || r_level == '0) begin
            w_next_level = '0;
            w_next_state = ENV_IDLE;
          end else if (w_tick) begin
            w_next_level = w_rel_diff[ENV_LEVEL_W] ? '0 : w_rel_diff[ENV_LEVEL_W-1:0];
          end
        end
        default: begin
          w_next_level = '0;
          w_next_state = ENV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state  <= ENV_IDLE;
      r_level  <= '0;
      r_gate   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_level  <= w_next_level;
      r_gate   <= gate_i;
      r_active <= (w_next_state != ENV_IDLE);
    end
  end

  assign volume_o = r_level[ENV_LEVEL_W-1:8];
  assign active_o = r_active;
  assign state_o  = r_state;

endmodule : audio_envelope
`default_nettype wire

// File: tb/tb_audio_envelope.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_audio_envelope: directed self-checking bench for audio_envelope.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_audio_envelope;

  logic       clk = 1'b0;
  logic       rstn;
  logic       gate;
  logic [7:0] attack;
  logic [7:0] decay;
  logic [7:0] sustain;
  logic [7:0] rel;
  logic [7:0] volume;
  logic       active;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  audio_envelope #(
    .TICK_DIV (4)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .gate_i    (gate),
    .attack_i  (attack),
    .decay_i   (decay),
    .sustain_i (sustain),
    .release_i (rel),
    .volume_o  (volume),
    .active_o  (active),
    .state_o   (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after rising edge number n (edges counted from reset release).
  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rstn = 1'b0; gate = 1'b1;
    attack = 8'hFF; decay = 8'h10; sustain = 8'h80; rel = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_volume", 16'(volume), 16'h00);
    check("reset_state",  16'(state),  16'h0);
    check("reset_active", 16'(active), 16'h0);
    rstn = 1'b1;
    cyc  = 0;

    // Full ADSR: rise seen on the first edge, ticks on every 4th edge
    wait_to(1);
    check("post_reset_state", 16'(state), 16'h1);
    check("post_reset_active", 16'(active), 16'h1);
    wait_to(1023);
    check("attack_255_vol", 16'(volume), 16'hFE);
    check("attack_255_state", 16'(state), 16'h1);
    wait_to(1024);
    check("attack_256_vol", 16'(volume), 16'hFF);
    check("attack_256_state", 16'(state), 16'h2);
    wait_to(1088);
    check("decay_16_vol", 16'(volume), 16'hFE);
    wait_to(9152);
    check("decay_end_vol", 16'(volume), 16'h80);
    check("decay_end_state", 16'(state), 16'h2);
    wait_to(9153);
    check("sustain_state", 16'(state), 16'h3);
    check("sustain_vol", 16'(volume), 16'h80);
    wait_to(9160);
    gate = 1'b0;
    wait_to(9161);
    check("release_state", 16'(state), 16'h4);
    wait_to(9668);
    check("release_127_vol", 16'(volume), 16'h01);
    wait_to(9676);
    check("release_129_vol", 16'(volume), 16'h00);
    check("release_129_state", 16'(state), 16'h4);
    wait_to(9677);
    check("idle_state", 16'(state), 16'h0);
    check("idle_active", 16'(active), 16'h0);
    check("idle_vol", 16'(volume), 16'h00);

    // Instant rates
    attack = 8'h00; decay = 8'h00; sustain = 8'h40;
    wait_to(9680);
    gate = 1'b1;
    wait_to(9681);
    check("inst_attack_state", 16'(state), 16'h1);
    wait_to(9682);
    check("inst_peak_vol", 16'(volume), 16'hFF);
    wait_to(9683);
    check("inst_sus_vol", 16'(volume), 16'h40);
    check("inst_sus_state", 16'(state), 16'h3);
    sustain = 8'h60;
    wait_to(9684);
    check("live_sustain_vol", 16'(volume), 16'h60);

    // Retrigger during release
    rel = 8'h80; attack = 8'h40; gate = 1'b0;
    wait_to(9812);
    check("retrig_rel_vol", 16'(volume), 16'h50);
    check("retrig_rel_state", 16'(state), 16'h4);
    gate = 1'b1;
    wait_to(9813);
    check("retrig_state", 16'(state), 16'h1);
    check("retrig_vol_kept", 16'(volume), 16'h50);
    wait_to(9827);
    check("retrig_3ticks_vol", 16'(volume), 16'h50);
    wait_to(9828);
    check("retrig_4ticks_vol", 16'(volume), 16'h51);

    // Back to IDLE through instant release
    gate = 1'b0; rel = 8'h00;
    wait_to(9830);
    check("inst_release_state", 16'(state), 16'h0);
    check("inst_release_vol", 16'(volume), 16'h00);

    // Edge/tick collision: rise sampled on tick edge 9832
    attack = 8'h80;
    wait_to(9831);
    gate = 1'b1;
    wait_to(9832);
    check("collide_state", 16'(state), 16'h1);
    check("collide_vol", 16'(volume), 16'h00);
    wait_to(9839);
    check("collide_one_step_vol", 16'(volume), 16'h00);
    wait_to(9840);
    check("collide_two_step_vol", 16'(volume), 16'h01);

    // One-cycle gate pulse
    gate = 1'b0;
    wait_to(9842);
    check("pre_pulse_state", 16'(state), 16'h0);
    attack = 8'h10; rel = 8'h40;
    wait_to(9843);
    gate = 1'b1;
    wait_to(9844);
    check("pulse_attack_state", 16'(state), 16'h1);
    gate = 1'b0;
    wait_to(9845);
    check("pulse_release_state", 16'(state), 16'h4);
    wait_to(9846);
    check("pulse_idle_state", 16'(state), 16'h0);
    check("pulse_idle_vol", 16'(volume), 16'h00);
    check("pulse_idle_active", 16'(active), 16'h0);

    // Reset mid-note
    gate = 1'b1;
    wait_to(9848);
    check("midnote_state", 16'(state), 16'h1);
    rstn = 1'b0;
    wait_to(9849);
    check("midnote_reset_state", 16'(state), 16'h0);
    check("midnote_reset_active", 16'(active), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_audio_envelope
`default_nettype wire
